// File: rtl/bc_horner.sv
// Control block for the Horner polynomial datapath.
// Evaluates acc = c[n]; then acc = acc*x + c[i] for i = n-1..0, where the
// degree n is latched at start. Drives the datapath register loads, the mux
// selects, the multiplier strobe and the coefficient index. Moore outputs.
module bc_horner #(
  parameter int CNT_W = 4,
  parameter int SEL_W = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             abort,
  input  logic [CNT_W-1:0] n_terms,
  output logic             LX,
  output logic [SEL_W-1:0] M0,
  output logic [SEL_W-1:0] M1,
  output logic [SEL_W-1:0] M2,
  output logic             H,
  output logic             LS,
  output logic             LH,
  output logic [CNT_W-1:0] coef_idx,
  output logic             busy,
  output logic             done,
  output logic             ready
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOADX = 3'd1,
    INIT  = 3'd2,
    MUL   = 3'd3,
    ADD   = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;

  // State and loop-counter registers; reset overrides every other input.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state and counter update. The counter only decrements when it is
  // non-zero, so the maximum degree terminates without wrapping.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (enable && !abort) begin
          state_nxt = LOADX;
          cnt_nxt   = n_terms;
        end
      end
      LOADX: state_nxt = INIT;
      INIT, ADD: begin
        if (cnt == '0) begin
          state_nxt = DONE;
        end else begin
          cnt_nxt   = cnt - 1'b1;
          state_nxt = MUL;
        end
      end
      MUL:     state_nxt = ADD;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    // Abort cancels any active run, including the DONE cycle.
    if (abort && (state != IDLE)) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end
  end

  // Output decode from state only; coef_idx is the registered counter.
  always_comb begin
    LX       = 1'b0;
    M0       = '0;
    M1       = '0;
    M2       = '0;
    H        = 1'b0;
    LS       = 1'b0;
    LH       = 1'b0;
    done     = 1'b0;
    ready    = 1'b0;
    busy     = 1'b1;
    coef_idx = cnt;
    case (state)
      IDLE: begin
        ready = 1'b1;
        busy  = 1'b0;
      end
      LOADX: LX = 1'b1;
      INIT: begin
        M0 = SEL_W'(1);
        LS = 1'b1;
      end
      MUL: begin
        M1 = SEL_W'(1);
        M2 = SEL_W'(0);
        H  = 1'b1;
        LH = 1'b1;
      end
      ADD: begin
        M0 = SEL_W'(2);
        M1 = SEL_W'(2);
        M2 = SEL_W'(3);
        LS = 1'b1;
      end
      DONE:    done = 1'b1;
      default: begin
        ready = 1'b1;
        busy  = 1'b0;
      end
    endcase
  end

endmodule
